branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Parametrised successor to the fetch-stage single-entry branch predictor.
- Direct-mapped branch target buffer with per-entry N-bit saturating direction counters.
- Fetch gets a same-cycle predicted direction and target from the lookup port.
- Execute writes back the resolved outcome and the block flags mispredictions, counting them for performance monitoring.

Parameters:
- WORD_SIZE, 32, PC/target width in bits.
- ENTRIES, 16, number of BTB entries; power of two, ≥2.
- CTR_BITS, 2, direction counter width; ≥1.
- CNT_BITS, 16, mispredict performance counter width.
- Derived: IDX = log2(ENTRIES); index = pc[IDX+1:2]; tag = pc[WORD_SIZE-1:IDX+2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- pc_f  in  WORD_SIZE  fetch PC to look up.
- pred_taken_f  out  1  predicted taken for pc_f.
- pred_target_f  out  WORD_SIZE  predicted next PC for pc_f.
- update_en  in  1  resolved branch or jump present in execute.
- stall_e  in  1  execute stalled; suppresses update.
- update_pc  in  WORD_SIZE  PC of resolved branch.
- update_taken  in  1  actual direction.
- update_target  in  WORD_SIZE  actual taken target.
- update_pred_taken  in  1  prediction made at fetch, piped with the instruction.
- update_pred_target  in  WORD_SIZE  predicted target, piped with the instruction.
- flush_all  in  1  invalidate whole table (fence.i / context switch).
- mispredict_e  out  1  resolved branch was mispredicted.
- mispredict_count  out  CNT_BITS  saturating mispredict count.

Behaviour:
- Storage per entry: valid, tag, target, ctr[CTR_BITS-1:0].
- Weakly-not-taken value WNT = 2^(CTR_BITS-1)-1; weakly-taken value WT = 2^(CTR_BITS-1).
- Reset: on a rising clk edge with rst==0:
  - all valid bits = 0, all ctr = WNT;
  - mispredict_count = 0.
  - Tag and target contents are don't-care.
  - Reset overrides flush and update in the same cycle.
  - Reset asserted mid-stream discards the pending update.
- Lookup is combinational, zero latency:
  - hit = valid[idx] & (tag[idx] == tag(pc_f)).
  - pred_taken_f = hit & ctr[idx][MSB].
  - pred_target_f = pred_taken_f ? target[idx] : pc_f + 4, truncated to WORD_SIZE (wraps at top of address space).
  - Outputs reflect table state before the current edge; there is no bypass from a same-cycle update.
- Update is sequential. It is applied at the edge only when rst==1, !flush_all, update_en, and !stall_e.
  - Hit on update_pc:
    - update_taken=1: ctr increments, saturating at 2^CTR_BITS-1; target written with update_target.
    - update_taken=0: ctr decrements, saturating at 0; target unchanged.
  - Miss and update_taken=1: allocate (overwrite regardless of valid): valid=1, tag=tag(update_pc), target=update_target, ctr=WT.
  - Miss and update_taken=0: no allocation, no state change.
- flush_all, applied at the edge when rst==1:
  - all valid = 0, all ctr = WNT;
  - any same-cycle update is dropped;
  - mispredict_count is preserved.
- Misprediction, combinational:
  - mispredict_e = update_en & !stall_e & ((update_pred_taken != update_taken) | (update_taken & update_pred_taken & (update_pred_target != update_target))).
  - mispredict_e is still asserted during flush_all; it is not gated by flush.
- Mispredict counter:
  - increments at the edge when mispredict_e=1 and rst==1;
  - saturates at 2^CNT_BITS-1 (no wrap).
- Stall: a stalled cycle changes no state, so a branch held in execute for K cycles updates exactly once, in its final unstalled cycle.
- Lookup and update on the same index in the same cycle: the lookup returns the pre-update entry; the update commits at the edge.
- Update must not generate X: pc bits [1:0] are ignored everywhere.

Test Plan (ENTRIES=16, CTR_BITS=2, CNT_BITS=4; idx=pc[5:2], tag=pc[31:6]):
1. Cold lookup: rst=0 for one edge, then pc_f=0x100 → pred_taken_f=0, pred_target_f=0x104, mispredict_count=0.
2. Allocation and training:
   - update pc 0x100, taken, target 0x80, pred_taken 0 → mispredict_e=1 that cycle, count=1.
   - Next cycle pc_f=0x100 → pred_taken_f=1, pred_target_f=0x80.
   - Two further taken updates → ctr saturates at 3.
3. Hysteresis:
   - From ctr=3, one not-taken update → ctr=2, still predicts taken.
   - A second not-taken update → ctr=1, pred_taken_f=0, pred_target_f=0x104.
   - Three more not-taken updates → ctr stays 0.
4. Aliasing:
   - Taken update at pc 0x140 (same idx 0, different tag), target 0x200 → lookup 0x140 gives taken/0x200.
   - Lookup 0x100 now misses → not taken, 0x104.
   - Not-taken update to a missing pc 0x180 → table unchanged.
5. Stall, flush, and target mismatch:
   - update_en=1, stall_e=1 for 3 cycles → no state change, mispredict_e=0.
   - Update with flush_all=1 → all lookups miss afterwards, update dropped, count unchanged unless mispredicted.
   - pred taken/0x80 vs actual taken/0x90 → mispredict_e=1.
6. Saturation and reset mid-operation:
   - 20 consecutive mispredicts → count=15.
   - rst=0 asserted together with update_en=1 → count=0, table empty, update discarded.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb
//   Direct-mapped branch target buffer with per-entry saturating direction
//   counters. Fetch gets a zero-latency prediction; execute writes back the
//   resolved outcome, which trains the table and is scored for mispredicts.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   pc_f                     fetch PC to look up
//   pred_taken_f/_target_f   prediction for pc_f (pre-edge table state)
//   update_*                 resolved branch from execute plus the prediction
//                            that was made for it at fetch
//   stall_e                  execute stalled; no state changes
//   flush_all                invalidate the whole table
//   mispredict_e             resolved branch was mispredicted
//   mispredict_count         saturating mispredict count
module branch_predictor_btb #(
    parameter int WORD_SIZE = 32,
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] pc_f,
    output logic                 pred_taken_f,
    output logic [WORD_SIZE-1:0] pred_target_f,
    input  logic                 update_en,
    input  logic                 stall_e,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic                 update_taken,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_pred_taken,
    input  logic [WORD_SIZE-1:0] update_pred_target,
    input  logic                 flush_all,
    output logic                 mispredict_e,
    output logic [CNT_BITS-1:0]  mispredict_count
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = WORD_SIZE - IDX - 2;
    localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] WT  = CTR_BITS'(1 << (CTR_BITS - 1));

    logic [ENTRIES-1:0]                valid_q,  valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]     tag_q,    tag_d;
    logic [ENTRIES-1:0][WORD_SIZE-1:0] target_q, target_d;
    logic [ENTRIES-1:0][CTR_BITS-1:0]  ctr_q,    ctr_d;
    logic [CNT_BITS-1:0]               cnt_q,    cnt_d;

    // pc[1:0] never participate in index or tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^update_pc[1:0];

    logic [IDX-1:0]   idx_f, idx_u;
    logic [TAG_W-1:0] tag_f, tag_u;
    logic             hit_f, hit_u, upd_fire;

    assign idx_f = pc_f[IDX+1:2];
    assign tag_f = pc_f[WORD_SIZE-1:IDX+2];
    assign idx_u = update_pc[IDX+1:2];
    assign tag_u = update_pc[WORD_SIZE-1:IDX+2];

    // Lookup: purely from registered state, so a same-cycle update is not seen.
    assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_taken_f  = hit_f && ctr_q[idx_f][CTR_BITS-1];
    assign pred_target_f = pred_taken_f ? target_q[idx_f] : pc_f + WORD_SIZE'(4);

    assign upd_fire = update_en && !stall_e;
    assign hit_u    = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

    // A taken branch that was predicted taken can still mispredict on target.
    assign mispredict_e = upd_fire &&
        ((update_pred_taken != update_taken) ||
         (update_taken && update_pred_taken && (update_pred_target != update_target)));

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush_all) begin
            // Flush wins over any update in the same cycle.
            valid_d = '0;
            ctr_d   = {ENTRIES{WNT}};
        end else if (upd_fire) begin
            if (hit_u) begin
                if (update_taken) begin
                    if (ctr_q[idx_u] != '1) ctr_d[idx_u] = ctr_q[idx_u] + 1'b1;
                    target_d[idx_u] = update_target;
                end else if (ctr_q[idx_u] != '0) begin
                    ctr_d[idx_u] = ctr_q[idx_u] - 1'b1;
                end
            end else if (update_taken) begin
                // Only taken branches earn an entry; evict whatever was there.
                valid_d[idx_u]  = 1'b1;
                tag_d[idx_u]    = tag_u;
                target_d[idx_u] = update_target;
                ctr_d[idx_u]    = WT;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mispredict_e && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{WNT}};
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tag/target carry no reset value; they only matter behind a valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

    assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;
    localparam int WS = 32;
    localparam int NB = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [WS-1:0] pc_f;
    logic          pred_taken_f;
    logic [WS-1:0] pred_target_f;
    logic          update_en, stall_e, update_taken, update_pred_taken, flush_all;
    logic [WS-1:0] update_pc, update_target, update_pred_target;
    logic          mispredict_e;
    logic [NB-1:0] mispredict_count;

    branch_predictor_btb #(.WORD_SIZE(WS), .ENTRIES(16), .CTR_BITS(2), .CNT_BITS(NB)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .update_en(update_en), .stall_e(stall_e), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
        .flush_all(flush_all), .mispredict_e(mispredict_e),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-slot record, counter kept as a plain int 0..3.
    bit          m_v   [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_ctr [16];
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
        int i;
        i = int'(pc[5:2]);
        t = m_v[i] && (m_tag[i] == pc[31:6]) && (m_ctr[i] >= 2);
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        return update_en && !stall_e &&
               ((update_pred_taken != update_taken) ||
                (update_taken && update_pred_taken && (update_pred_target != update_target)));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0;
            m_ctr[i] = 1;
        end
    endtask

    task automatic m_commit(input bit mis);
        int i;
        bit hit;
        if (!rst) begin
            m_clear();
            m_cnt = 0;
            return;
        end
        if (mis && m_cnt < CMAX) m_cnt++;
        if (flush_all) begin
            m_clear();
            return;
        end
        if (!update_en || stall_e) return;
        i = int'(update_pc[5:2]);
        hit = m_v[i] && (m_tag[i] == update_pc[31:6]);
        if (hit) begin
            if (update_taken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = update_target;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (update_taken) begin
            m_v[i] = 1; m_tag[i] = update_pc[31:6]; m_tgt[i] = update_target; m_ctr[i] = 2;
        end
    endtask

    // One clock: check combinational outputs mid-cycle against the model, then commit.
    task automatic step();
        bit et, em;
        logic [31:0] etg;
        @(negedge clk);
        m_predict(pc_f, et, etg);
        em = m_mis();
        chk("pred_taken", {31'd0, pred_taken_f}, {31'd0, et});
        chk("pred_target", pred_target_f, etg);
        chk("mispredict_e", {31'd0, mispredict_e}, {31'd0, em});
        chk("count", {28'd0, mispredict_count}, m_cnt);
        @(posedge clk);
        m_commit(em);
        #1;
    endtask

    task automatic idle();
        update_en = 0; stall_e = 0; flush_all = 0; update_taken = 0;
        update_pred_taken = 0; update_pc = 0; update_target = 0; update_pred_target = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                       input bit pt, input logic [31:0] ptgt);
        update_en = 1; update_pc = pc; update_taken = t; update_target = tgt;
        update_pred_taken = pt; update_pred_target = ptgt;
        step();
        update_en = 0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input bit t, input logic [31:0] tgt);
        pc_f = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, pred_taken_f}, {31'd0, t});
        chk({tag, "_target"}, pred_target_f, tgt);
    endtask

    initial begin
        idle();
        m_cnt = 0;
        m_clear();
        rst = 0; pc_f = 32'h100;
        // 1. cold lookup
        step();
        rst = 1;
        look("cold", 32'h100, 0, 32'h104);
        chk("cold_count", {28'd0, mispredict_count}, 0);
        look("wrap", 32'hFFFF_FFFC, 0, 32'h0);
        pc_f = 32'h100;

        // 2. allocate and train
        update_en = 1; update_pc = 32'h100; update_taken = 1; update_target = 32'h80;
        update_pred_taken = 0; update_pred_target = 32'h104;
        #1 chk("alloc_mis", {31'd0, mispredict_e}, 1);
        step(); update_en = 0;
        chk("alloc_count", {28'd0, mispredict_count}, 1);
        look("trained", 32'h100, 1, 32'h80);
        upd(32'h100, 1, 32'h80, 1, 32'h80);
        upd(32'h100, 1, 32'h80, 1, 32'h80);

        // 3. hysteresis from saturated taken
        upd(32'h100, 0, 32'h80, 1, 32'h80);
        look("hyst1", 32'h100, 1, 32'h80);
        upd(32'h100, 0, 32'h80, 1, 32'h80);
        look("hyst2", 32'h100, 0, 32'h104);
        repeat (3) upd(32'h100, 0, 32'h80, 0, 32'h104);
        upd(32'h100, 1, 32'h80, 0, 32'h104);
        look("floor", 32'h100, 0, 32'h104);

        // 4. aliasing on index 0
        upd(32'h140, 1, 32'h200, 0, 32'h144);
        look("alias_new", 32'h140, 1, 32'h200);
        look("alias_old", 32'h100, 0, 32'h104);
        upd(32'h180, 0, 32'h0, 0, 32'h184);
        look("nt_miss", 32'h140, 1, 32'h200);
        look("nt_miss2", 32'h180, 0, 32'h184);

        // 5. stall, flush, target mismatch
        update_en = 1; stall_e = 1; update_pc = 32'h140; update_taken = 0;
        update_pred_taken = 1; update_pred_target = 32'h200;
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_mis", {31'd0, mispredict_e}, 0);
            step();
        end
        idle();
        look("stall_hold", 32'h140, 1, 32'h200);
        flush_all = 1;
        upd(32'h140, 1, 32'h200, 1, 32'h200);
        flush_all = 0;
        look("flushed", 32'h140, 0, 32'h144);
        upd(32'h100, 1, 32'h80, 0, 32'h104);
        update_en = 1; update_pc = 32'h100; update_taken = 1; update_target = 32'h90;
        update_pred_taken = 1; update_pred_target = 32'h80;
        #1 chk("tgt_mis", {31'd0, mispredict_e}, 1);
        step(); idle();

        // 6. counter saturation, reset mid-stream
        repeat (20) upd(32'h100, 1, 32'h80, 0, 32'h104);
        chk("sat_count", {28'd0, mispredict_count}, 15);
        rst = 0;
        update_en = 1; update_pc = 32'h300; update_taken = 1; update_target = 32'h500;
        update_pred_taken = 0;
        step(); idle(); rst = 1;
        chk("rst_count", {28'd0, mispredict_count}, 0);
        look("rst_tbl", 32'h100, 0, 32'h104);
        look("rst_upd", 32'h300, 0, 32'h304);

        // Randomized traffic over a small PC pool so entries collide and retrain.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pcs [2];
            logic [31:0] tgts [3];
            bit pt;
            logic [31:0] ptg;
            tgts[0] = 32'h80; tgts[1] = 32'h90; tgts[2] = 32'h200;
            for (int j = 0; j < 2; j++) begin
                logic [25:0] tg;
                case ($urandom_range(3))
                    0: tg = 26'd0;
                    1: tg = 26'd1;
                    2: tg = 26'd2;
                    default: tg = 26'h3FF_FFFF;
                endcase
                pcs[j] = {tg, 2'($urandom_range(3)), 2'd0, 2'($urandom_range(3))};
            end
            pc_f = pcs[0];
            update_pc = pcs[1];
            rst = ($urandom_range(63) != 0);
            flush_all = ($urandom_range(31) == 0);
            stall_e = ($urandom_range(3) == 0);
            update_en = $urandom_range(1);
            update_taken = $urandom_range(1);
            update_target = tgts[$urandom_range(2)];
            if ($urandom_range(1) != 0) begin
                m_predict(update_pc, pt, ptg);
            end else begin
                pt = $urandom_range(1);
                ptg = tgts[$urandom_range(2)];
            end
            update_pred_taken = pt;
            update_pred_target = ptg;
            step();
        end
        rst = 1;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
